// File: rtl/residue.sv
// Multi-word residue 2^nn mod M by bit-serial double-and-reduce.
// Word 0 is the most significant word; M is read from the shared modulus memory.
module residue (
  input  logic        clk,
  input  logic        reset,
  input  logic        calculate,
  output logic        ready,
  input  logic [7:0]  length,
  input  logic [13:0] nn,
  output logic [7:0]  opm_addr,
  input  logic [31:0] opm_data,
  output logic [7:0]  res_addr,
  input  logic [31:0] res_rd_data,
  output logic [31:0] res_wr_data,
  output logic        res_we
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_CMP_A, S_CMP_D, S_SUB_A, S_SUB_D, S_SHL_A, S_SHL_D, S_DONE
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  addr_reg, addr_next;
  logic [7:0]  len_reg, len_next;
  logic [13:0] rem_reg, rem_next;
  // Borrow during SUB, shifted-out bit during SHIFT.
  logic        flag_reg, flag_next;

  logic [7:0]  last_idx;
  logic        last_word;
  logic        first_word;
  logic        rem_zero;
  logic [32:0] sub_full;

  assign last_idx   = len_reg - 8'd1;
  assign last_word  = (addr_reg == last_idx);
  assign first_word = (addr_reg == 8'd0);
  assign rem_zero   = (rem_reg == 14'd0);
  assign sub_full   = {1'b0, res_rd_data} - {1'b0, opm_data} - {32'd0, flag_reg};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      addr_reg  <= 8'd0;
      len_reg   <= 8'd0;
      rem_reg   <= 14'd0;
      flag_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      len_reg   <= len_next;
      rem_reg   <= rem_next;
      flag_reg  <= flag_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    len_next   = len_reg;
    rem_next   = rem_reg;
    flag_next  = flag_reg;
    case (state_reg)
      S_IDLE: begin
        if (calculate) begin
          len_next   = length;
          rem_next   = nn;
          addr_next  = 8'd0;
          flag_next  = 1'b0;
          state_next = (length == 8'd0) ? S_DONE : S_INIT;
        end
      end
      S_INIT: begin
        if (last_word) begin
          addr_next  = 8'd0;
          state_next = S_CMP_A;
        end else begin
          addr_next = addr_reg + 8'd1;
        end
      end
      S_CMP_A: state_next = S_CMP_D;
      S_CMP_D: begin
        if ((res_rd_data > opm_data) || ((res_rd_data == opm_data) && last_word)) begin
          addr_next  = last_idx;
          flag_next  = 1'b0;
          state_next = S_SUB_A;
        end else if (res_rd_data < opm_data) begin
          addr_next  = rem_zero ? 8'd0 : last_idx;
          flag_next  = 1'b0;
          state_next = rem_zero ? S_IDLE : S_SHL_A;
        end else begin
          addr_next  = addr_reg + 8'd1;
          state_next = S_CMP_A;
        end
      end
      S_SUB_A: state_next = S_SUB_D;
      S_SUB_D: begin
        flag_next = sub_full[32];
        if (first_word) begin
          addr_next  = rem_zero ? 8'd0 : last_idx;
          flag_next  = 1'b0;
          state_next = rem_zero ? S_IDLE : S_SHL_A;
        end else begin
          addr_next  = addr_reg - 8'd1;
          state_next = S_SUB_A;
        end
      end
      S_SHL_A: state_next = S_SHL_D;
      S_SHL_D: begin
        flag_next = res_rd_data[31];
        if (first_word) begin
          rem_next = rem_reg - 14'd1;
          // A bit carried out of the top word means res >= 2^(32*length) > M.
          if (res_rd_data[31]) begin
            addr_next  = last_idx;
            flag_next  = 1'b0;
            state_next = S_SUB_A;
          end else begin
            addr_next  = 8'd0;
            state_next = S_CMP_A;
          end
        end else begin
          addr_next  = addr_reg - 8'd1;
          state_next = S_SHL_A;
        end
      end
      S_DONE: begin
        addr_next  = 8'd0;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready       = (state_reg == S_IDLE);
    res_addr    = addr_reg;
    opm_addr    = addr_reg;
    res_we      = 1'b0;
    res_wr_data = 32'd0;
    case (state_reg)
      S_INIT: begin
        res_we      = 1'b1;
        res_wr_data = last_word ? 32'd1 : 32'd0;
      end
      S_SUB_D: begin
        res_we      = 1'b1;
        res_wr_data = sub_full[31:0];
      end
      S_SHL_D: begin
        res_we      = 1'b1;
        res_wr_data = {res_rd_data[30:0], flag_reg};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_residue.sv
// Randomized bench for residue: bench-side memories plus a big-integer model of 2^nn mod M.
module tb_residue;
  logic        tb_clk = 1'b0;
  logic        reset;
  logic        calculate;
  logic        ready;
  logic [7:0]  length;
  logic [13:0] nn;
  logic [7:0]  opm_addr;
  logic [31:0] opm_data;
  logic [7:0]  res_addr;
  logic [31:0] res_rd_data;
  logic [31:0] res_wr_data;
  logic        res_we;

  logic [31:0] mod_mem [0:255];
  logic [31:0] res_mem [0:255];

  int tests = 0;
  int fails = 0;
  int run_len = 0;
  int wr_count = 0;

  always #5 tb_clk = ~tb_clk;

  residue dut (
    .clk(tb_clk), .reset(reset), .calculate(calculate), .ready(ready),
    .length(length), .nn(nn), .opm_addr(opm_addr), .opm_data(opm_data),
    .res_addr(res_addr), .res_rd_data(res_rd_data), .res_wr_data(res_wr_data),
    .res_we(res_we)
  );

  always @(posedge tb_clk) begin
    opm_data    <= mod_mem[opm_addr];
    res_rd_data <= res_mem[res_addr];
    if (res_we) res_mem[res_addr] <= res_wr_data;
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every write must target a word of the running operand, on a shared address.
  always @(negedge tb_clk) begin
    if (!reset && res_we) begin
      wr_count++;
      check("we_addr_range", 256'(int'(res_addr) < run_len), 256'(1));
      check("addr_shared", 256'(opm_addr), 256'(res_addr));
    end
  end

  function automatic logic [255:0] model_res(input logic [255:0] m, input int n);
    logic [255:0] r;
    r = 256'(1) % m;
    for (int k = 0; k < n; k++) r = (r << 1) % m;
    return r;
  endfunction

  function automatic logic [255:0] pack_mod(input int len);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < len; i++) v = (v << 32) | 256'(mod_mem[i]);
    return v;
  endfunction

  function automatic logic [255:0] pack_res(input int len);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < len; i++) v = (v << 32) | 256'(res_mem[i]);
    return v;
  endfunction

  task automatic start_run(input int len, input int n);
    run_len  = len;
    wr_count = 0;
    @(negedge tb_clk);
    calculate = 1'b1;
    length    = 8'(len);
    nn        = 14'(n);
    @(posedge tb_clk);
    #1;
    calculate = 1'b0;
    length    = 8'($urandom);
    nn        = 14'($urandom);
    check("ready_fall", 256'(ready), 256'(0));
  endtask

  task automatic wait_done(input int budget, input bit poke, output int cycles);
    cycles = 0;
    while (!ready && cycles < budget) begin
      @(posedge tb_clk);
      #1;
      calculate = 1'b0;
      cycles++;
      if (poke && cycles == 5) begin
        calculate = 1'b1;
        length    = 8'($urandom_range(1, 4));
        nn        = 14'($urandom_range(0, 9));
      end
    end
    calculate = 1'b0;
    if (!ready) check("timeout", 256'(0), 256'(1));
  endtask

  task automatic do_case(input int len, input int n, input bit poke,
                         input bit has_lit, input logic [255:0] lit);
    int cycles;
    int bound;
    logic [255:0] dut_v;
    logic [255:0] exp_v;
    bound = len + 2 + (n + 1) * (6 * len + 2);
    start_run(len, n);
    wait_done(bound + 20, poke, cycles);
    dut_v = pack_res(len);
    exp_v = model_res(pack_mod(len), n);
    check("result", dut_v, exp_v);
    if (has_lit) begin
      check("result_literal", dut_v, lit);
      check("model_literal", exp_v, lit);
    end
    check("latency", 256'(cycles <= bound), 256'(1));
    $display("[TB] len=%0d nn=%0d poke=%0d cycles=%0d res=%0h exp=%0h",
             len, n, poke, cycles, dut_v, exp_v);
  endtask

  initial begin
    int cycles;
    int len;
    int n;
    reset = 1'b1;
    calculate = 1'b0;
    length = 8'd0;
    nn = 14'd0;
    for (int i = 0; i < 256; i++) begin
      mod_mem[i] = '0;
      res_mem[i] = '0;
    end
    #1;
    check("reset_ready", 256'(ready), 256'(1));
    check("reset_we", 256'(res_we), 256'(0));
    check("reset_addr", 256'(res_addr), 256'(0));
    repeat (3) @(posedge tb_clk);
    @(negedge tb_clk);
    reset = 1'b0;

    mod_mem[0] = 32'h13;
    do_case(1, 64, 1'b0, 1'b1, 256'h11);
    do_case(1, 0, 1'b0, 1'b1, 256'h1);
    mod_mem[0] = 32'h1;
    do_case(1, 5, 1'b0, 1'b1, 256'h0);
    mod_mem[0] = 32'hFFFFFFFB;
    do_case(1, 32, 1'b0, 1'b1, 256'h5);
    do_case(1, 64, 1'b0, 1'b1, 256'h19);
    mod_mem[0] = 32'h1;
    mod_mem[1] = 32'h1;
    do_case(2, 32, 1'b0, 1'b1, 256'h00000001_00000000);
    do_case(2, 33, 1'b0, 1'b1, 256'h00000000_FFFFFFFF);
    do_case(2, 33, 1'b1, 1'b1, 256'h00000000_FFFFFFFF);

    start_run(0, 7);
    wait_done(3, 1'b0, cycles);
    check("len0_ready", 256'(ready), 256'(1));
    check("len0_writes", 256'(wr_count), 256'(0));
    $display("[TB] len=0 nn=7 cycles=%0d writes=%0d", cycles, wr_count);

    start_run(2, 33);
    repeat (20) @(posedge tb_clk);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_ready", 256'(ready), 256'(1));
    check("midreset_we", 256'(res_we), 256'(0));
    check("midreset_addr", 256'(res_addr), 256'(0));
    $display("[TB] reset asserted mid-run ready=%0b we=%0b", ready, res_we);
    @(negedge tb_clk);
    reset = 1'b0;
    do_case(2, 33, 1'b0, 1'b1, 256'h00000000_FFFFFFFF);

    for (int k = 0; k < 12; k++) begin
      len = $urandom_range(1, 4);
      n   = $urandom_range(0, 100);
      for (int i = 0; i < len; i++) mod_mem[i] = $urandom;
      if (k % 3 == 0) mod_mem[0] = 32'($urandom_range(0, 3));
      if (pack_mod(len) == '0) mod_mem[len - 1] = 32'd1;
      do_case(len, n, (k % 4) == 1, 1'b0, '0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
